// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: four-slot time-division owner of a single-port tilemap/sprite SRAM.
// Accesses following an odd decision slot belong to video fetch. Accesses following an
// even decision slot go to the master or sub CPU by arbitration.
// All SRAM controls and all strobes are registered, so no input reaches an output
// combinationally.
module vram_slot_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 13,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter bit          PRIORITY_MASTER = 1'b0
) (
    input  logic                  CLK_6M,
    input  logic                  rst,
    input  logic                  phase_sync,
    input  logic                  vid_en,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  vid_valid,
    input  logic                  m_req,
    input  logic                  m_we,
    input  logic [ADDR_WIDTH-1:0] m_addr,
    input  logic [DATA_WIDTH-1:0] m_wdata,
    output logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  m_ack,
    input  logic                  s_req,
    input  logic                  s_we,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  s_ack,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  sram_dout_en,
    input  logic [DATA_WIDTH-1:0] sram_din,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    // Kind of SRAM access occupying a cycle; acc_q is the access happening now.
    typedef enum logic [2:0] {
        ACC_IDLE,
        ACC_VID,
        ACC_M_RD,
        ACC_M_WR,
        ACC_S_RD,
        ACC_S_WR
    } acc_e;

    logic [1:0] slot_q;
    logic [1:0] slot_cur;
    logic [1:0] slot_d;
    acc_e       acc_q;
    acc_e       acc_d;
    logic       rr_sub_q;   // 1 = sub CPU received the most recent grant
    logic       busy_m_q;
    logic       busy_s_q;
    logic       m_elig;
    logic       s_elig;
    logic       grant_m;
    logic       grant_s;
    logic       rd_d;
    logic       wr_d;

    // Current slot, CPU arbitration and the access kind for the following cycle
    always_comb begin
        slot_cur = phase_sync ? 2'd0 : slot_q;
        slot_d   = slot_cur + 2'd1;
        m_elig   = m_req && !busy_m_q;
        s_elig   = s_req && !busy_s_q;
        grant_m  = 1'b0;
        grant_s  = 1'b0;
        acc_d    = ACC_IDLE;
        if (slot_cur[0]) begin
            if (vid_en) acc_d = ACC_VID;
        end else begin
            if (m_elig && s_elig) begin
                if (PRIORITY_MASTER || rr_sub_q) grant_m = 1'b1;
                else                             grant_s = 1'b1;
            end else begin
                grant_m = m_elig;
                grant_s = s_elig;
            end
            if (grant_m)      acc_d = m_we ? ACC_M_WR : ACC_M_RD;
            else if (grant_s) acc_d = s_we ? ACC_S_WR : ACC_S_RD;
        end
        rd_d = (acc_d == ACC_VID) || (acc_d == ACC_M_RD) || (acc_d == ACC_S_RD);
        wr_d = (acc_d == ACC_M_WR) || (acc_d == ACC_S_WR);
    end

    // Slot counter, registered SRAM controls, busy/round-robin state and completion strobes
    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            slot_q       <= '0;
            acc_q        <= ACC_IDLE;
            rr_sub_q     <= 1'b1;
            busy_m_q     <= 1'b0;
            busy_s_q     <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_dout_en <= 1'b0;
            sram_addr    <= '0;
            sram_dout    <= '0;
            vid_valid    <= 1'b0;
            vid_data     <= '0;
            m_ack        <= 1'b0;
            m_rdata      <= '0;
            s_ack        <= 1'b0;
            s_rdata      <= '0;
        end else begin
            slot_q       <= slot_d;
            acc_q        <= acc_d;
            sram_ce_n    <= (acc_d == ACC_IDLE);
            sram_oe_n    <= !rd_d;
            sram_we_n    <= !wr_d;
            sram_dout_en <= wr_d;
            case (acc_d)
                ACC_VID:            sram_addr <= vid_addr;
                ACC_M_RD, ACC_M_WR: sram_addr <= m_addr;
                ACC_S_RD, ACC_S_WR: sram_addr <= s_addr;
                default:            ;
            endcase
            if (acc_d == ACC_M_WR) sram_dout <= m_wdata;
            if (acc_d == ACC_S_WR) sram_dout <= s_wdata;

            // Busy drops at the end of the ack cycle; a grant can never coincide with it.
            if (m_ack)   busy_m_q <= 1'b0;
            if (grant_m) busy_m_q <= 1'b1;
            if (s_ack)   busy_s_q <= 1'b0;
            if (grant_s) busy_s_q <= 1'b1;
            if (grant_m)      rr_sub_q <= 1'b0;
            else if (grant_s) rr_sub_q <= 1'b1;

            vid_valid <= (acc_q == ACC_VID);
            if (acc_q == ACC_VID) vid_data <= sram_din;
            m_ack <= (acc_q == ACC_M_RD) || (acc_q == ACC_M_WR);
            if (acc_q == ACC_M_RD) m_rdata <= sram_din;
            s_ack <= (acc_q == ACC_S_RD) || (acc_q == ACC_S_WR);
            if (acc_q == ACC_S_RD) s_rdata <= sram_din;
        end
    end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb_vram_slot_arbiter: scoreboard bench with a behavioural SRAM for vram_slot_arbiter.
// A second instance with master priority shares the inputs for arbitration checks.
module tb_vram_slot_arbiter;

    logic        CLK_6M;
    logic        rst, phase_sync, vid_en;
    logic [12:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        m_req, m_we, m_ack;
    logic [12:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;
    logic        s_req, s_we, s_ack;
    logic [12:0] s_addr;
    logic [7:0]  s_wdata, s_rdata;
    logic [12:0] sram_addr;
    logic [7:0]  sram_dout, sram_din;
    logic        sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n;

    logic [7:0]  p_vid_data, p_m_rdata, p_s_rdata, p_sram_dout, p_din;
    logic [12:0] p_sram_addr;
    logic        p_vid_valid, p_m_ack, p_s_ack, p_dout_en, p_ce_n, p_oe_n, p_we_n;

    vram_slot_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .PRIORITY_MASTER(1'b0)) u_dut (
        .CLK_6M(CLK_6M), .rst(rst), .phase_sync(phase_sync), .vid_en(vid_en),
        .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
        .sram_din(sram_din), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    vram_slot_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .PRIORITY_MASTER(1'b1)) u_dut_p (
        .CLK_6M(CLK_6M), .rst(rst), .phase_sync(phase_sync), .vid_en(vid_en),
        .vid_addr(vid_addr), .vid_data(p_vid_data), .vid_valid(p_vid_valid),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(p_m_rdata), .m_ack(p_m_ack),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(p_s_rdata), .s_ack(p_s_ack),
        .sram_addr(p_sram_addr), .sram_dout(p_sram_dout), .sram_dout_en(p_dout_en),
        .sram_din(p_din), .sram_ce_n(p_ce_n), .sram_oe_n(p_oe_n),
        .sram_we_n(p_we_n)
    );

    assign p_din = 8'h00;

    initial CLK_6M = 1'b0;
    always #5 CLK_6M = ~CLK_6M;

    // Behavioural SRAM with a preload port
    logic [7:0]  mem [0:8191];
    logic        pre_en;
    logic [12:0] pre_addr;
    logic [7:0]  pre_data;

    always @(posedge CLK_6M) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (!sram_ce_n && !sram_we_n && sram_dout_en) mem[sram_addr] <= sram_dout;
    end
    assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'hFF;

    int unsigned cyc = 0;
    always @(posedge CLK_6M) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned p0       = 0;
    int unsigned we_cnt   = 0;
    logic [7:0]  m_last, s_last;

    typedef struct {
        int unsigned data;
        int unsigned cyc;
    } exp_t;
    exp_t m_exp[$];
    exp_t s_exp[$];
    exp_t v_exp[$];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned slot_of(input int unsigned c);
        return (c - p0) % 4;
    endfunction

    // Output monitor: pops scoreboard entries on every strobe
    always @(negedge CLK_6M) begin
        exp_t e;
        if (vid_valid) begin
            if (v_exp.size() == 0) check("vid_valid_spurious", 1, 0);
            else begin
                e = v_exp.pop_front();
                check("vid_data", 32'(vid_data), e.data);
                check("vid_valid_cycle", cyc, e.cyc);
            end
        end
        if (m_ack) begin
            if (m_exp.size() == 0) check("m_ack_spurious", 1, 0);
            else begin
                e = m_exp.pop_front();
                check("m_rdata", 32'(m_rdata), e.data);
                check("m_ack_cycle", cyc, e.cyc);
            end
        end
        if (s_ack) begin
            if (s_exp.size() == 0) check("s_ack_spurious", 1, 0);
            else begin
                e = s_exp.pop_front();
                check("s_rdata", 32'(s_rdata), e.data);
                check("s_ack_cycle", cyc, e.cyc);
            end
        end
        if (!sram_we_n) begin
            we_cnt++;
            check("we_in_odd_slot", slot_of(cyc) % 2, 1);
        end
    end

    task automatic tick();
        @(posedge CLK_6M);
        #1;
    endtask

    task automatic wait_slot(input int unsigned s);
        for (int i = 0; i < 4 && slot_of(cyc) != s; i++) tick();
    endtask

    task automatic sync_now();
        phase_sync = 1'b1;
        p0 = cyc;
        tick();
        phase_sync = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_last = 8'h00;
        s_last = 8'h00;
        sync_now();
    endtask

    task automatic vid_read(input logic [12:0] a, input logic [7:0] d);
        exp_t e;
        wait_slot(3);
        vid_addr = a;
        vid_en   = 1'b1;
        e.data = 32'(d);
        e.cyc  = cyc + 2;
        v_exp.push_back(e);
        tick();
        check("vid_ctrl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}), 32'b0010);
        check("vid_sram_addr", 32'(sram_addr), 32'(a));
        vid_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic cpu_op(input bit sub, input logic we, input logic [12:0] a,
                          input logic [7:0] wd, input logic [7:0] rd);
        exp_t        e;
        int unsigned t;
        bit          done;
        t = cyc;
        while (slot_of(t) % 2 != 0) t++;
        e.cyc = t + 2;
        if (sub) begin
            e.data = we ? 32'(s_last) : 32'(rd);
            if (!we) s_last = rd;
            s_exp.push_back(e);
            s_we = we; s_addr = a; s_wdata = wd; s_req = 1'b1;
        end else begin
            e.data = we ? 32'(m_last) : 32'(rd);
            if (!we) m_last = rd;
            m_exp.push_back(e);
            m_we = we; m_addr = a; m_wdata = wd; m_req = 1'b1;
        end
        done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            tick();
            done = sub ? s_ack : m_ack;
        end
        if (!done) check(sub ? "s_ack_timeout" : "m_ack_timeout", 0, 1);
        m_req = 1'b0;
        s_req = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned t;
        int unsigned we_base;
        exp_t        e;
        rst = 1'b1; phase_sync = 1'b0; vid_en = 1'b0; vid_addr = '0;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
        pre_en = 1'b1; pre_addr = 13'h0A5; pre_data = 8'h3C;
        m_last = 8'h00; s_last = 8'h00;
        tick();
        pre_en = 1'b0;
        tick();
        check("rst_sram_addr", 32'(sram_addr), 0);
        check("rst_sram_dout", 32'(sram_dout), 0);
        check("rst_vid_data", 32'(vid_data), 0);
        check("rst_m_rdata", 32'(m_rdata), 0);
        check("rst_s_rdata", 32'(s_rdata), 0);

        // T1: idle after reset with phase_sync at t0
        rst = 1'b0;
        sync_now();
        for (int i = 0; i < 16; i++) begin
            check("idle_ctrl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}), 32'b1110);
            tick();
        end

        // T2: video read of a preloaded location
        vid_read(13'h0A5, 8'h3C);

        // T3: master write then read back; sub write/read at the top address
        we_base = we_cnt;
        cpu_op(1'b0, 1'b1, 13'h1234, 8'h55, 8'h00);
        cpu_op(1'b0, 1'b0, 13'h1234, 8'h00, 8'h55);
        check("m_we_pulses", we_cnt - we_base, 1);
        cpu_op(1'b1, 1'b1, 13'h1FFF, 8'hA7, 8'h00);
        cpu_op(1'b1, 1'b0, 13'h1FFF, 8'h00, 8'hA7);
        vid_read(13'h1FFF, 8'hA7);

        // T4: both CPUs held continuously from reset -> M,S,M,S on both priority modes
        do_reset();
        wait_slot(0);
        t = cyc;
        m_we = 1'b0; m_addr = 13'h1234; s_we = 1'b0; s_addr = 13'h0A5;
        m_req = 1'b1; s_req = 1'b1;
        e.data = 32'h55; e.cyc = t + 2; m_exp.push_back(e);
        e.data = 32'h3C; e.cyc = t + 4; s_exp.push_back(e);
        e.data = 32'h55; e.cyc = t + 6; m_exp.push_back(e);
        e.data = 32'h3C; e.cyc = t + 8; s_exp.push_back(e);
        m_last = 8'h55; s_last = 8'h3C;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) m_req = 1'b0;
            if (k == 8) s_req = 1'b0;
            if (k % 2 == 0)
                check("prio_alt_ack", 32'({p_m_ack, p_s_ack}), (k % 4 == 2) ? 2 : 1);
        end
        tick();

        // T4b: master granted last, then both contend: round-robin picks sub, priority picks master
        cpu_op(1'b0, 1'b0, 13'h1234, 8'h00, 8'h55);
        t = cyc;
        m_req = 1'b1; s_req = 1'b1;
        e.data = 32'h3C; e.cyc = t + 3; s_exp.push_back(e);
        e.data = 32'h55; e.cyc = t + 5; m_exp.push_back(e);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 3) check("prio_contend_first", 32'({p_m_ack, p_s_ack}), 2);
            if (k == 4) s_req = 1'b0;
            if (k == 5) begin
                check("prio_contend_second", 32'({p_m_ack, p_s_ack}), 1);
                m_req = 1'b0;
            end
        end
        tick();

        // T5: phase_sync lands in the ack cycle of an in-flight read
        wait_slot(0);
        t = cyc;
        m_we = 1'b0; m_addr = 13'h1234; m_req = 1'b1;
        e.data = 32'h55; e.cyc = t + 2; m_exp.push_back(e);
        tick();
        tick();
        m_req = 1'b0;
        sync_now();
        vid_read(13'h0A5, 8'h3C);
        wait_slot(1);
        sync_now();
        vid_read(13'h1FFF, 8'hA7);
        cpu_op(1'b1, 1'b0, 13'h0A5, 8'h00, 8'h3C);

        // T6: reset the cycle after a grant aborts the access, re-request proceeds
        wait_slot(0);
        m_we = 1'b0; m_addr = 13'h1234; m_req = 1'b1;
        tick();
        check("t6_access_started", 32'({sram_ce_n, sram_oe_n}), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        p0 = cyc;
        check("t6_no_ack", 32'(m_ack), 0);
        check("t6_ctrl_idle", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}), 32'b1110);
        check("t6_rdata_cleared", 32'(m_rdata), 0);
        m_last = 8'h55; s_last = 8'h00;
        e.data = 32'h55; e.cyc = cyc + 2; m_exp.push_back(e);
        tick();
        tick();
        check("t6_regrant_ack", 32'(m_ack), 1);
        m_req = 1'b0;
        tick();
        tick();

        check("m_exp_drained", m_exp.size(), 0);
        check("s_exp_drained", s_exp.size(), 0);
        check("v_exp_drained", v_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
